// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes through EX/MEM/WB and raises the ID-stage stall.
// Optional build macro FULL_INTERLOCK_EN: no forwarding, so any in-flight writer of a source stalls.
module hazard_scoreboard #(
  parameter int NREG = 8,
  parameter int RW   = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_wr_en,
  input  logic [RW-1:0]   id_wr_reg,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            mem_valid,
  output logic            wb_valid,
  output logic [RW-1:0]   ex_wr_reg,
  output logic [RW-1:0]   mem_wr_reg,
  output logic [RW-1:0]   wb_wr_reg,
  output logic            ex_is_load,
  output logic [NREG-1:0] pending_mask,
  output logic [CNTW-1:0] stall_cycles
);

  logic            ex_valid_q, ex_valid_d;
  logic            mem_valid_q, mem_valid_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RW-1:0]   ex_wr_reg_q, ex_wr_reg_d;
  logic [RW-1:0]   mem_wr_reg_q, mem_wr_reg_d;
  logic [RW-1:0]   wb_wr_reg_q, wb_wr_reg_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;

  logic advance;
  logic hazard_rs;
  logic hazard_rt;
  logic stall_s;
  logic issue_s;

  function automatic logic stage_hit(input logic v, input logic [RW-1:0] tag,
                                     input logic [RW-1:0] r);
    stage_hit = v & (tag == r);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] r);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << r;
  endfunction

  // Consumer hazard detection against the in-flight writers.
  always_comb begin
`ifdef FULL_INTERLOCK_EN
    hazard_rs = id_rs_used & (stage_hit(ex_valid_q, ex_wr_reg_q, id_rs) |
                              stage_hit(mem_valid_q, mem_wr_reg_q, id_rs) |
                              stage_hit(wb_valid_q, wb_wr_reg_q, id_rs));
    hazard_rt = id_rt_used & (stage_hit(ex_valid_q, ex_wr_reg_q, id_rt) |
                              stage_hit(mem_valid_q, mem_wr_reg_q, id_rt) |
                              stage_hit(wb_valid_q, wb_wr_reg_q, id_rt));
`else
    // Only a load in EX cannot be forwarded in time.
    hazard_rs = id_rs_used & ex_is_load_q & stage_hit(ex_valid_q, ex_wr_reg_q, id_rs);
    hazard_rt = id_rt_used & ex_is_load_q & stage_hit(ex_valid_q, ex_wr_reg_q, id_rt);
`endif
    stall_s = id_valid & ~flush & (hazard_rs | hazard_rt);
    issue_s = id_valid & id_wr_en & ~stall_s & ~flush;
    advance = ~mem_stall;
  end

  // Pipeline shift of writer entries and the saturating stall counter.
  always_comb begin
    if (advance) begin
      wb_valid_d   = mem_valid_q;
      wb_wr_reg_d  = mem_wr_reg_q;
      mem_valid_d  = ex_valid_q;
      mem_wr_reg_d = ex_wr_reg_q;
      if (issue_s) begin
        ex_valid_d   = 1'b1;
        ex_wr_reg_d  = id_wr_reg;
        ex_is_load_d = id_is_load;
      end else begin
        ex_valid_d   = 1'b0;
        ex_wr_reg_d  = {RW{1'b0}};
        ex_is_load_d = 1'b0;
      end
      if (stall_s && (stall_cycles_q != {CNTW{1'b1}})) begin
        stall_cycles_d = stall_cycles_q + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
    end else begin
      wb_valid_d     = wb_valid_q;
      wb_wr_reg_d    = wb_wr_reg_q;
      mem_valid_d    = mem_valid_q;
      mem_wr_reg_d   = mem_wr_reg_q;
      ex_valid_d     = ex_valid_q;
      ex_wr_reg_d    = ex_wr_reg_q;
      ex_is_load_d   = ex_is_load_q;
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers; reset wins over freeze and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      mem_valid_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      ex_wr_reg_q    <= {RW{1'b0}};
      mem_wr_reg_q   <= {RW{1'b0}};
      wb_wr_reg_q    <= {RW{1'b0}};
      ex_is_load_q   <= 1'b0;
      stall_cycles_q <= {CNTW{1'b0}};
    end else begin
      ex_valid_q     <= ex_valid_d;
      mem_valid_q    <= mem_valid_d;
      wb_valid_q     <= wb_valid_d;
      ex_wr_reg_q    <= ex_wr_reg_d;
      mem_wr_reg_q   <= mem_wr_reg_d;
      wb_wr_reg_q    <= wb_wr_reg_d;
      ex_is_load_q   <= ex_is_load_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_id     = stall_s;
  assign ex_valid     = ex_valid_q;
  assign mem_valid    = mem_valid_q;
  assign wb_valid     = wb_valid_q;
  assign ex_wr_reg    = ex_wr_reg_q;
  assign mem_wr_reg   = mem_wr_reg_q;
  assign wb_wr_reg    = wb_wr_reg_q;
  assign ex_is_load   = ex_is_load_q;
  assign stall_cycles = stall_cycles_q;
  assign pending_mask = (ex_valid_q  ? onehot(ex_wr_reg_q)  : {NREG{1'b0}}) |
                        (mem_valid_q ? onehot(mem_wr_reg_q) : {NREG{1'b0}}) |
                        (wb_valid_q  ? onehot(wb_wr_reg_q)  : {NREG{1'b0}});

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a writer-list reference model checked every cycle.
module tb_hazard_scoreboard;
  localparam int NREG = 8;
  localparam int RW   = 3;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;
`ifdef FULL_INTERLOCK_EN
  localparam int SC_LU = 3, SC_ALU = 6, SC_FRZ = 9, ALU_STALL = 1;
  localparam logic [7:0] PM_LU = 8'h10, PM_ALU = 8'h20;
`else
  localparam int SC_LU = 1, SC_ALU = 1, SC_FRZ = 2, ALU_STALL = 0;
  localparam logic [7:0] PM_LU = 8'h18, PM_ALU = 8'h28;
`endif

  logic clk = 1'b0;
  logic rst, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush, mem_stall;
  logic [RW-1:0] id_rs, id_rt, id_wr_reg;
  logic stall_id, ex_valid, mem_valid, wb_valid, ex_is_load;
  logic [RW-1:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic [NREG-1:0] pending_mask;
  logic [CNTW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
    .stall_id(stall_id), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg),
    .ex_is_load(ex_is_load), .pending_mask(pending_mask), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: list of issued writers, each with its age in advancing cycles
  // (0 = EX, 1 = MEM, 2 = WB).
  typedef struct {int pos; logic [RW-1:0] r; logic ld;} wr_t;
  wr_t inflight[$];
  int  m_cnt = 0;
  bit  model_live = 1'b0;

  function automatic logic m_dep(input logic [RW-1:0] src);
    foreach (inflight[i]) begin
`ifdef FULL_INTERLOCK_EN
      if (inflight[i].r == src) return 1'b1;
`else
      if (inflight[i].pos == 0 && inflight[i].ld && inflight[i].r == src) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return id_valid && !flush &&
           ((id_rs_used && m_dep(id_rs)) || (id_rt_used && m_dep(id_rt)));
  endfunction

  function automatic logic [RW+1:0] m_stage(input int p);
    foreach (inflight[i])
      if (inflight[i].pos == p) return {1'b1, inflight[i].r, inflight[i].ld};
    return '0;
  endfunction

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] m = '0;
    foreach (inflight[i]) m[inflight[i].r] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin : model
    logic s;
    if (rst) begin
      inflight.delete();
      m_cnt = 0;
      model_live = 1'b1;
    end else if (!mem_stall) begin
      s = m_stall();
      if (s && m_cnt < CMAX) m_cnt++;
      foreach (inflight[i]) inflight[i].pos++;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].pos > 2) inflight.delete(i);
      if (id_valid && id_wr_en && !s && !flush)
        inflight.push_back('{pos: 0, r: id_wr_reg, ld: id_is_load});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin : compare
    logic [RW+1:0] e0, e1, e2;
    if (model_live) begin
      e0 = m_stage(0); e1 = m_stage(1); e2 = m_stage(2);
      chk("stall_id", {31'd0, stall_id}, {31'd0, m_stall()});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e0[RW+1]});
      chk("ex_wr_reg", {29'd0, ex_wr_reg}, {29'd0, e0[RW:1]});
      chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, e0[0]});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, e1[RW+1]});
      chk("mem_wr_reg", {29'd0, mem_wr_reg}, {29'd0, e1[RW:1]});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e2[RW+1]});
      chk("wb_wr_reg", {29'd0, wb_wr_reg}, {29'd0, e2[RW:1]});
      chk("pending_mask", {24'd0, pending_mask}, {24'd0, m_pending()});
      chk("stall_cycles", {28'd0, stall_cycles}, m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [RW-1:0] rs, input logic ru,
                       input logic [RW-1:0] rt, input logic tu, input logic we,
                       input logic [RW-1:0] wr, input logic ld, input logic fl,
                       input logic ms);
    id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld; flush = fl; mem_stall = ms;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic nop();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  // Hold the current ID instruction until it stops stalling, then let it pass.
  task automatic issue();
    for (int i = 0; i < 8; i++) begin
      if (!m_stall()) break;
      tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    // Reset while frozen and with a live instruction in ID.
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst pending", {24'd0, pending_mask}, 32'h00);
    chk("rst stall_cycles", {28'd0, stall_cycles}, 32'd0);
    chk("rst stall_id", {31'd0, stall_id}, 32'd0);
    drain();

    // Load-use: ld r3 ; add r4, r3, r2
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("lu stall_id", {31'd0, stall_id}, 32'd1);
    chk("lu pending", {24'd0, pending_mask}, 32'h08);
    chk("lu ex_is_load", {31'd0, ex_is_load}, 32'd1);
`ifndef FULL_INTERLOCK_EN
    tick();
    chk("lu bubble stall_id", {31'd0, stall_id}, 32'd0);
    chk("lu bubble ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu bubble mem_wr_reg", {29'd0, mem_wr_reg}, 32'd3);
    chk("lu bubble pending", {24'd0, pending_mask}, 32'h08);
    tick();
`else
    issue();
`endif
    nop();
    chk("lu ex_wr_reg", {29'd0, ex_wr_reg}, 32'd4);
    chk("lu pending after", {24'd0, pending_mask}, {24'd0, PM_LU});
    chk("lu stall_cycles", {28'd0, stall_cycles}, SC_LU);
    drain();

    // ALU-to-ALU: add r3 ; sub r5, r3, r1
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("alu stall_id", {31'd0, stall_id}, ALU_STALL);
    issue();
    nop();
    chk("alu ex_wr_reg", {29'd0, ex_wr_reg}, 32'd5);
    chk("alu pending", {24'd0, pending_mask}, {24'd0, PM_ALU});
    chk("alu stall_cycles", {28'd0, stall_cycles}, SC_ALU);
    drain();

    // Memory freeze with a load-use pair waiting.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz stall_id", {31'd0, stall_id}, 32'd1);
      chk("frz ex_wr_reg", {29'd0, ex_wr_reg}, 32'd3);
      chk("frz ex_is_load", {31'd0, ex_is_load}, 32'd1);
      chk("frz stall_cycles", {28'd0, stall_cycles}, SC_ALU);
    end
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    issue();
    nop();
    chk("frz ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("frz ex_wr_reg after", {29'd0, ex_wr_reg}, 32'd6);
    chk("frz stall_cycles after", {28'd0, stall_cycles}, SC_FRZ);
    drain();

    // Flush beats the load-use hazard.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    chk("fl stall_id", {31'd0, stall_id}, 32'd0);
    tick();
    nop();
    chk("fl ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl pending", {24'd0, pending_mask}, 32'h08);
    chk("fl stall_cycles", {28'd0, stall_cycles}, SC_FRZ);
    drain();

    // Saturation: repeated load-use pairs, consumer reads r1 on both sources, no write.
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("sat stall_id", {31'd0, stall_id}, 32'd1);
      issue();
    end
    nop();
    chk("sat stall_cycles", {28'd0, stall_cycles}, 32'hF);
    drain();

    // Mid-run reset with a load in flight, memory frozen and flush asserted.
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst2 ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst2 pending", {24'd0, pending_mask}, 32'h00);
    chk("rst2 stall_cycles", {28'd0, stall_cycles}, 32'd0);
    chk("rst2 stall_id", {31'd0, stall_id}, 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage operand forwarding logic.
- Tracks every in-flight register write through the EX, MEM and WB stages of the 5-stage WISC pipeline.
- Publishes per-stage destination tags and a pending-write mask. Decides when the ID-stage consumer must stall (load-use, or full interlock when forwarding is compiled out).
- Sits alongside the ID/EX pipeline register. Driven by decode outputs and the memory-system stall.

Parameters:
- NREG, 8, number of architectural registers (r0 is general purpose, not hardwired).
- RW, 3, register index width (log2 NREG).
- CNTW, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction (0 = bubble/nop)
- id_rs  in  RW  source register A index
- id_rt  in  RW  source register B index
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  RW  destination register (already resolved from RegDst, incl. r7 for jal)
- id_is_load  in  1  instruction is a data-memory read
- flush  in  1  squash the ID instruction (branch/jump redirect)
- mem_stall  in  1  data/instruction memory busy; whole pipeline frozen
- stall_id  out  1  hold PC and IF/ID, inject bubble into EX
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a pending write
- ex_wr_reg, mem_wr_reg, wb_wr_reg  out  RW each  destination tag per stage
- ex_is_load  out  1  EX-stage writer is a load
- pending_mask  out  NREG  bit r set if any valid stage writes r
- stall_cycles  out  CNTW  saturating count of cycles with stall_id=1

Behaviour:
- Reset (rst=1 at posedge):
  - all stage valid bits clear, tags cleared to 0, ex_is_load clears.
  - stall_cycles clears to 0.
  - stall_id and pending_mask read 0 in the cycle after reset.
  - Reset overrides mem_stall and flush.
- Stage entry: {valid, wr_reg, is_load}. Registered.
- advance = ~mem_stall.
- On advance:
  - wb <= mem; mem <= ex.
  - ex <= new entry if id_valid & id_wr_en & ~stall_id & ~flush, else a bubble (valid=0, tag 0).
- On mem_stall: all three entries hold. stall_cycles holds.
- hazard_rs = id_rs_used & match(id_rs); hazard_rt = id_rt_used & match(id_rt).
- Default match(r) = ex_valid & ex_is_load & (ex_wr_reg == r). This is the load-use case; every other dependency is covered by forwarding.
- stall_id = id_valid & ~flush & (hazard_rs | hazard_rt). Combinational; no latency.
- A load-use stall lasts exactly 1 advancing cycle: the load moves to MEM and the bubble enters EX.
- flush takes priority over a hazard: the flushed instruction never stalls and never enters EX.
- Same register on rs and rt: a single stall, no double count.
- Instructions with id_wr_en=0 (stores, branches) can still stall as consumers but insert no entry.
- pending_mask: OR over the valid stages of one-hot(wr_reg). Combinational from registered state.
- stall_cycles: +1 on each posedge where stall_id=1 and advance=1. Saturates at all-ones; no wrap.

Optional Feature:
- Macro FULL_INTERLOCK_EN.
- Defined: forwarding is assumed absent.
  - match(r) = any valid stage among EX, MEM, WB with wr_reg == r, regardless of is_load.
  - The register file has no write-through, so a WB match also stalls.
  - A dependent instruction right behind an ALU producer stalls 3 cycles.
- Undefined: load-use-only matching as above.

Test Plan:
- Reset: rst=1 with mem_stall=1 and id_valid=1 -> next cycle every *_valid=0, pending_mask=8'h00, stall_cycles=0, stall_id=0.
- Load-use: ld r3 then add r4,r3,r2 -> stall_id=1 for exactly 1 cycle; ex_valid=0 bubble next; pending_mask=8'h08 while ld is in flight; stall_cycles=1.
- ALU-to-ALU: add r3 then sub r5,r3,r1 -> stall_id stays 0. Under FULL_INTERLOCK_EN, stall_id=1 for 3 cycles and stall_cycles=3.
- Memory freeze: ld r3 in EX, consumer in ID, mem_stall=1 for 4 cycles -> entries hold, stall_id stays 1, stall_cycles unchanged; after release, one counted stall then the consumer enters EX.
- Flush priority: load-use pair with flush=1 on the consumer cycle -> stall_id=0, the next ex_valid=0, pending_mask shows only r3.
- Saturation: force 2^CNTW+5 stall cycles (use CNTW=4 override: 21 cycles) -> stall_cycles ends at 4'hF.
